// File: rtl/block_output_pkg.sv
// -----------------------------------------------------------------------------
// block_output_pkg
//   Shared definitions for the transmit end of the router-to-router link:
//   default geometry, header field offsets, FSM state encoding and the
//   packet-position helper used by the framing logic.
//   No ports (package).
// -----------------------------------------------------------------------------
package block_output_pkg;

  localparam int DW_DEF      = 8;   // flit width
  localparam int PKT_LEN_DEF = 4;   // flits per packet (header + body/tail)
  localparam int DEPTH_DEF   = 4;   // FIFO depth in flits

  // flit_cnt is a fixed 2-bit port, so PKT_LEN is limited to 2..4.
  localparam int FLIT_CNT_W = 2;
  localparam int DEST_W     = 4;

  // Header field offsets: dest = {X, Y}.
  localparam int DEST_X_HI = 3;
  localparam int DEST_X_LO = 2;
  localparam int DEST_Y_HI = 1;
  localparam int DEST_Y_LO = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Position of the next flit within a packet, wrapping after the tail.
  function automatic logic [FLIT_CNT_W-1:0] next_flit_cnt(
    input logic [FLIT_CNT_W-1:0] cnt,
    input int                    pkt_len
  );
    if (cnt == FLIT_CNT_W'(pkt_len - 1)) begin
      return '0;
    end
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/block_output_flit_fifo.sv
// -----------------------------------------------------------------------------
// flit_fifo
//   Synchronous DEPTH x DW flit FIFO. The head entry stays in the FIFO until
//   it is popped, so the consumer can present it for as long as it likes.
//   A push into a full FIFO is accepted only when a pop frees a slot in the
//   same cycle; otherwise the data is dropped.
//
//   Ports:
//     clk, rst     clock (rising edge), asynchronous active-low reset
//     push, din    write request and data
//     push_ack     the push is actually taken this cycle
//     pop          remove the head entry (ignored when empty)
//     head         entry at the read pointer
//     head_next    entry behind the head (valid when count >= 2)
//     full, empty  occupancy flags
//     count        number of stored flits
// -----------------------------------------------------------------------------
module flit_fifo
  import block_output_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          din,
  output logic                   push_ack,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic [DW-1:0]          head_next,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [AW-1:0] rd_ptr_inc;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign do_pop   = pop && !empty;
  // When full, the slot being freed by this cycle's pop is the one written.
  assign do_push  = push && (!full || do_pop);
  assign push_ack = do_push;

  // DEPTH is a power of two, so the pointers wrap naturally.
  assign rd_ptr_inc = rd_ptr_q + 1'b1;
  assign head       = mem[rd_ptr_q];
  assign head_next  = mem[rd_ptr_inc];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_inc;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/block_output.sv
// -----------------------------------------------------------------------------
// block_output
//   Transmit end of a router-to-router link. Flits from the crossbar are
//   buffered in a small FIFO and serialised to the downstream block_input
//   with a val/ret handshake (val & ret in one cycle = flit accepted).
//   Fixed-length packet framing drives busy/flit_cnt/dest for the switch
//   allocator.
//
//   Ports:
//     clk, rst     clock (rising edge), asynchronous active-low reset
//     wr_en        crossbar pushes wr_data this cycle
//     wr_data      flit from crossbar
//     full         FIFO full; crossbar must not push
//     val          Data_out holds a valid flit
//     ret          downstream acknowledge
//     Data_out     flit to downstream node (holds last value when val=0)
//     busy         packet in progress on this port
//     flit_cnt     index of the Data_out flit within its packet (0 = header)
//     dest         {X,Y} of the current packet, captured from the header
// -----------------------------------------------------------------------------
module block_output
  import block_output_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PKT_LEN = PKT_LEN_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DW-1:0]         wr_data,
  output logic                  full,
  output logic                  val,
  input  logic                  ret,
  output logic [DW-1:0]         Data_out,
  output logic                  busy,
  output logic [FLIT_CNT_W-1:0] flit_cnt,
  output logic [DEST_W-1:0]     dest
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  tx_state_e             state_q, state_d;
  logic [DW-1:0]         data_q, data_d;
  logic [FLIT_CNT_W-1:0] flit_cnt_q, flit_cnt_d;
  logic [DEST_W-1:0]     dest_q, dest_d;
  logic                  busy_q, busy_d;

  logic                  fifo_empty;
  logic                  push_ack;
  logic [CNT_W-1:0]      fifo_count;
  logic [DW-1:0]         fifo_head;
  logic [DW-1:0]         fifo_head_next;
  logic                  accept;
  logic                  more_queued;
  logic                  is_tail;

  // The presented flit is the FIFO head; it is removed only on acceptance.
  assign accept = (state_q == SEND) && ret;

  flit_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .din       (wr_data),
    .push_ack  (push_ack),
    .pop       (accept),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .full      (full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Another flit remains behind the one being accepted.
  assign more_queued = (fifo_count > CNT_W'(1));
  assign is_tail     = (flit_cnt_q == FLIT_CNT_W'(PKT_LEN - 1));

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    flit_cnt_d = flit_cnt_q;
    dest_d     = dest_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = SEND;
          data_d  = fifo_head;
        end
      end
      SEND: begin
        if (ret) begin
          if (more_queued) begin
            data_d = fifo_head_next;
          end else if (push_ack) begin
            // FIFO held only the accepted flit; the flit being written now
            // is the next head, so forward it directly.
            data_d = wr_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      flit_cnt_d = next_flit_cnt(flit_cnt_q, PKT_LEN);
      if (flit_cnt_q == '0) begin
        dest_d = {data_q[DEST_X_HI:DEST_X_LO], data_q[DEST_Y_HI:DEST_Y_LO]};
      end
    end

    // Packets are fixed length, so whatever is queued after a tail is the
    // next header and keeps the port busy.
    if (push_ack) begin
      busy_d = 1'b1;
    end
    if (accept && is_tail) begin
      busy_d = more_queued || push_ack;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      flit_cnt_q <= '0;
      dest_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      flit_cnt_q <= flit_cnt_d;
      dest_q     <= dest_d;
      busy_q     <= busy_d;
    end
  end

  assign val      = (state_q == SEND);
  assign Data_out = data_q;
  assign busy     = busy_q;
  assign flit_cnt = flit_cnt_q;
  assign dest     = dest_q;

endmodule

// File: doc/block_output.md
Name: block_output

Overview:
- Transmit end of the router-to-router link: the partner of block_input on the other side of the same val/ret/Data wires.
- Accepts 8-bit flits from the router crossbar into a small FIFO.
- Serialises them to the downstream node's input block using the val/ret handshake.
- Tracks packet framing (fixed-length packets) so the switch allocator knows when the output port is busy.

Parameters:
- DEPTH, 4, FIFO depth in flits; power of two, >= 2.
- PKT_LEN, 4, flits per packet (header + PKT_LEN-1 body/tail flits).
- DW, 8, flit width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  crossbar pushes wr_data this cycle.
- wr_data  in  DW  flit from crossbar.
- full  out  1  FIFO full; crossbar must not assert wr_en.
- val  out  1  request: Data_out holds a valid flit for the downstream block_input.
- ret  in  1  downstream acknowledge; val&ret in the same cycle = flit accepted.
- Data_out  out  DW  flit to the downstream node.
- busy  out  1  packet in progress on this port (header sent or queued, tail not yet accepted).
- flit_cnt  out  2  index within the current packet of the flit on Data_out (0 = header).
- dest  out  4  {X,Y} of the current packet, header bits [3:0]; held until the tail is accepted.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - FIFO pointers and count; full=0.
  - val=0, Data_out=0, busy=0, flit_cnt=0, dest=0.
  - FSM returns to IDLE.
  - Applies mid-packet too: any partial packet is discarded and no flit is re-sent after release.
- FIFO:
  - Write when wr_en && !full.
  - wr_en while full is ignored; the data is dropped and stays out of the FIFO.
  - Pop when val && ret.
  - Simultaneous push and pop when full is legal only if the pop frees the slot that cycle; count stays unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: val=0. If FIFO non-empty, go to SEND next cycle, loading Data_out from the FIFO head.
  - SEND: val=1, Data_out stable and equal to the FIFO head.
    - ret=0: stay; Data_out and val are held unchanged.
    - ret=1 and FIFO holds another flit: stay in SEND and present the next flit the following cycle (back-to-back, 1 flit/cycle peak).
    - ret=1 and FIFO empty after the pop: go to IDLE, val=0 next cycle.
- ret while val=0 is ignored.
- Latency: flit written at cycle N (FIFO previously empty) appears with val=1 at cycle N+2.
- Framing:
  - flit_cnt increments on each accepted flit and wraps to 0 after PKT_LEN-1.
  - On an accepted flit with flit_cnt=0, dest is captured from Data_out[3:0].
  - busy rises on the first push of a header and falls the cycle after the tail (flit_cnt=PKT_LEN-1) is accepted, unless the next header is already queued, in which case busy stays 1.
- Data_out keeps its last value while val=0.

Decomposition:
- Shared package: DW, PKT_LEN, header field offsets (DEST_X=[3:2], DEST_Y=[1:0]), FSM state encoding (IDLE=0, SEND=1).
- One sub-module: flit_fifo (synchronous FIFO, DEPTH x DW, full/empty/count), reused later in block_input's buffer.

Test Plan:
- Reset, push 8'hAF, 8'hFA, 8'hF8, 8'hF0 on consecutive cycles with ret tied 1 -> val high 4 consecutive cycles, Data_out AF,FA,F8,F0, flit_cnt 0..3, dest=4'hF, busy falls after F0, val=0 afterward.
- Same packet with ret=0 for 5 cycles before each ack -> Data_out held stable for 5 cycles per flit, no flit lost or duplicated, flit_cnt advances only on ack.
- ret=0 permanently, push 6 flits -> full=1 after 4, flits 5-6 dropped, val=1 on AF. Release ret -> exactly 4 flits delivered in order.
- Full FIFO with simultaneous wr_en and val&ret -> count stays 4, new flit delivered last, order intact.
- rst pulsed low asynchronously (mid-cycle) after 2 of 4 flits accepted -> val, busy, flit_cnt, Data_out=0 immediately; FIFO empty; no output after release until a new push.
- ret pulsed with val=0 in IDLE -> no state change, flit_cnt stays 0.
